// File: rtl/branch_pkg.sv
// Shared branch-control definitions: BranchOp encoding, op width and the
// condition-evaluation helper used by the PC unit.
package branch_pkg;

  localparam int OP_W = 3;

  typedef logic [OP_W-1:0] br_op_t;

  localparam br_op_t BR_NOP  = 3'b000;
  localparam br_op_t BR_BR   = 3'b001;
  localparam br_op_t BR_BMI  = 3'b010;
  localparam br_op_t BR_BPL  = 3'b011;
  localparam br_op_t BR_BZ   = 3'b100;
  localparam br_op_t BR_BNZ  = 3'b101;
  localparam br_op_t BR_CALL = 3'b110;
  localparam br_op_t BR_RET  = 3'b111;

  // True when a target-redirecting op wants the target. RET is resolved
  // against the return stack by the caller, so it reports 0 here.
  function automatic logic target_taken(br_op_t op, logic zero, logic neg);
    logic hit;
    hit = 1'b0;
    case (op)
      BR_BR, BR_CALL: hit = 1'b1;
      BR_BMI:         hit = neg;
      BR_BPL:         hit = !neg;
      BR_BZ:          hit = zero;
      BR_BNZ:         hit = !zero;
      default:        hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/branch_pc_unit_if.sv
// Control/status bundle between the control unit and branch_pc_unit.
// master = control-unit/datapath side, slave = the PC unit.
interface branch_pc_unit_if #(parameter int ADDR_W = 32);
  import branch_pkg::*;

  logic              en;
  br_op_t            BranchOp;
  logic              zero;
  logic              neg;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] PCout;
  logic              taken;
  logic              ras_full;
  logic              ras_empty;
  logic              ras_err;
  logic [31:0]       taken_count;

  modport master (
    output en, BranchOp, zero, neg, target,
    input  PCout, taken, ras_full, ras_empty, ras_err, taken_count
  );

  modport slave (
    input  en, BranchOp, zero, neg, target,
    output PCout, taken, ras_full, ras_empty, ras_err, taken_count
  );

endinterface

// File: rtl/ras_stack.sv
// Circular return-address stack. A push while full overwrites the oldest
// entry; a pop while empty leaves state untouched. overflow/underflow are
// combinational and valid only alongside the push/pop that caused them.
module ras_stack #(
  parameter int ADDR_W    = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] pop_data,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic              underflow
);

  localparam int PTR_W = $clog2(RAS_DEPTH);

  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
  logic [ADDR_W-1:0] mem_d [RAS_DEPTH];
  logic [PTR_W-1:0]  top_idx;

  // ptr_q is the next free slot; it wraps naturally since RAS_DEPTH is 2^n.
  assign top_idx   = ptr_q - PTR_W'(1);
  assign pop_data  = mem_q[top_idx];
  assign full      = (count_q == (PTR_W+1)'(RAS_DEPTH));
  assign empty     = (count_q == '0);
  assign overflow  = push && full;
  assign underflow = pop && empty;

  // Next pointer, occupancy and storage; push and pop never coincide.
  always_comb begin
    // NOTE: every output gets a default first, so no path leaves a latch.
    ptr_d   = ptr_q;
    count_d = count_q;
    mem_d   = mem_q;
    if (push) begin
      mem_d[ptr_q] = push_data;
      ptr_d        = ptr_q + PTR_W'(1);
      if (!full) count_d = count_q + (PTR_W+1)'(1);
    end else if (pop && !empty) begin
      ptr_d   = top_idx;
      count_d = count_q - (PTR_W+1)'(1);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all state so every flop samples
    // pre-edge values regardless of block evaluation order.
    if (rst) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; count_q alone decides which entries are
    // live, so stale contents are never observed.
    mem_q <= mem_d;
  end

endmodule

// File: rtl/branch_pc_unit.sv
// Program counter and branch control: selects next PC from BranchOp, ALU
// flags, an absolute target or the return-address stack.
// Optional build macro BRANCH_STATS_EN enables the saturating taken_count
// counter; without it taken_count is tied to 0.
module branch_pc_unit
  import branch_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                PC_STEP   = 4,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int                RAS_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  branch_pc_unit_if.slave    bus
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              taken_q, taken_d;
  logic              ras_err_q, ras_err_d;
  logic [ADDR_W-1:0] seq;
  logic [ADDR_W-1:0] ras_top;
  logic              push, pop, redirect;
  logic              ras_full, ras_empty, ras_ovf, ras_udf;

  assign seq = pc_q + ADDR_W'(PC_STEP);

  ras_stack #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_data (seq),
    .pop_data  (ras_top),
    .full      (ras_full),
    .empty     (ras_empty),
    .overflow  (ras_ovf),
    .underflow (ras_udf)
  );

  // Decode the op into stack actions and a redirect decision (enabled only).
  always_comb begin
    push     = 1'b0;
    pop      = 1'b0;
    redirect = 1'b0;
    if (bus.en) begin
      if (bus.BranchOp == BR_RET) begin
        pop      = 1'b1;
        redirect = !ras_empty;
      end else begin
        push     = (bus.BranchOp == BR_CALL);
        redirect = target_taken(bus.BranchOp, bus.zero, bus.neg);
      end
    end
  end

  // Next PC and the registered status pulses; a stall holds PC.
  always_comb begin
    pc_d      = pc_q;
    taken_d   = 1'b0;
    ras_err_d = 1'b0;
    if (bus.en) begin
      if (!redirect)                    pc_d = seq;
      else if (bus.BranchOp == BR_RET)  pc_d = ras_top;
      else                              pc_d = bus.target;
      taken_d   = redirect;
      ras_err_d = ras_ovf || ras_udf;
    end
  end

  // PC and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      taken_q   <= 1'b0;
      ras_err_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      taken_q   <= taken_d;
      ras_err_q <= ras_err_d;
    end
  end

  assign bus.PCout     = pc_q;
  assign bus.taken     = taken_q;
  assign bus.ras_err   = ras_err_q;
  assign bus.ras_full  = ras_full;
  assign bus.ras_empty = ras_empty;

`ifdef BRANCH_STATS_EN
  logic [31:0] taken_count_q, taken_count_d;

  // Count redirects, saturating at all-ones.
  always_comb begin
    taken_count_d = taken_count_q;
    if (taken_d && (taken_count_q != 32'hFFFF_FFFF))
      taken_count_d = taken_count_q + 32'd1;
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) taken_count_q <= '0;
    else     taken_count_q <= taken_count_d;
  end

  assign bus.taken_count = taken_count_q;
`else
  assign bus.taken_count = '0;
`endif

endmodule

// File: tb/tb_branch_pc_unit.sv
// Self-checking bench for branch_pc_unit: directed scenarios plus a random
// run, all compared against a queue-based behavioural model.
module tb_branch_pc_unit;
  import branch_pkg::*;

  localparam int D = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_pc_unit_if #(.ADDR_W(32)) bus ();

  branch_pc_unit #(
    .ADDR_W    (32),
    .PC_STEP   (4),
    .RESET_PC  (32'h0),
    .RAS_DEPTH (D)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state.
  logic [31:0] m_pc;
  logic        m_taken;
  logic        m_err;
  logic [31:0] m_cnt;
  logic [31:0] ras_m[$];

  // Drive one cycle, advance the model, and return #1 after the edge.
  task automatic apply(input logic r, input logic e, input br_op_t op,
                       input logic z, input logic n, input logic [31:0] t);
    logic [31:0] seq;
    rst = r; bus.en = e; bus.BranchOp = op;
    bus.zero = z; bus.neg = n; bus.target = t;
    seq = m_pc + 32'd4;
    m_taken = 1'b0;
    m_err   = 1'b0;
    if (r) begin
      m_pc = 32'h0; ras_m.delete(); m_cnt = 32'h0;
    end else if (e) begin
      case (op)
        BR_NOP:  m_pc = seq;
        BR_BR:   m_taken = 1'b1;
        BR_BMI:  m_taken = (n === 1'b1);
        BR_BPL:  m_taken = (n === 1'b0);
        BR_BZ:   m_taken = (z === 1'b1);
        BR_BNZ:  m_taken = (z === 1'b0);
        BR_CALL: begin
          ras_m.push_back(seq);
          if (ras_m.size() > D) begin
            void'(ras_m.pop_front());
            m_err = 1'b1;
          end
          m_taken = 1'b1;
        end
        default: begin
          if (ras_m.size() > 0) begin
            m_pc = ras_m.pop_back();
            m_taken = 1'b1;
          end else begin
            m_pc = seq;
            m_err = 1'b1;
          end
        end
      endcase
      if (op != BR_NOP && op != BR_RET) m_pc = m_taken ? t : seq;
`ifdef BRANCH_STATS_EN
      if (m_taken && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
`endif
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply(1'b1, 1'b1, BR_BR, 1'b0, 1'b0, 32'h80);
    n_cmp++; if (bus.PCout !== 32'h0) begin n_bad++; $display("FAIL reset_pc: got %h want %h", bus.PCout, 32'h0); end
    n_cmp++; if (bus.taken !== 1'b0) begin n_bad++; $display("FAIL reset_taken: got %b want 0", bus.taken); end
    n_cmp++; if (bus.ras_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", bus.ras_err); end
    n_cmp++; if (bus.ras_empty !== 1'b1 || bus.ras_full !== 1'b0) begin n_bad++; $display("FAIL reset_ras: empty %b full %b want 1 0", bus.ras_empty, bus.ras_full); end
    n_cmp++; if (bus.taken_count !== 32'h0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", bus.taken_count); end
    for (int i = 1; i <= 3; i++) begin
      apply(1'b0, 1'b1, BR_NOP, 1'bx, 1'bx, 32'hxxxx_xxxx);
      n_cmp++; if (bus.PCout !== 32'(4*i) || bus.taken !== 1'b0) begin n_bad++; $display("FAIL seq_nop%0d: pc %h taken %b want %h 0", i, bus.PCout, bus.taken, 32'(4*i)); end
    end
  endtask

  task automatic test_conditional();
    apply(1'b0, 1'b1, BR_NOP, 1'b0, 1'b0, 32'h0);
    n_cmp++; if (bus.PCout !== 32'h10) begin n_bad++; $display("FAIL cond_start: got %h want 10", bus.PCout); end
    apply(1'b0, 1'b1, BR_BZ, 1'b1, 1'b0, 32'h40);
    n_cmp++; if (bus.PCout !== 32'h40 || bus.taken !== 1'b1) begin n_bad++; $display("FAIL bz_taken: pc %h taken %b want 40 1", bus.PCout, bus.taken); end
    apply(1'b0, 1'b1, BR_BZ, 1'b0, 1'b0, 32'h80);
    n_cmp++; if (bus.PCout !== 32'h44 || bus.taken !== 1'b0) begin n_bad++; $display("FAIL bz_not: pc %h taken %b want 44 0", bus.PCout, bus.taken); end
    for (int i = 0; i < 20; i++) begin
      br_op_t op;
      op = br_op_t'($urandom_range(1, 5));
      apply(1'b0, 1'b1, op, 1'($urandom), 1'($urandom), {$urandom_range(0, 255), 2'b00});
      n_cmp++; if (bus.PCout !== m_pc || bus.taken !== m_taken) begin n_bad++; $display("FAIL cond_op%0d: pc %h taken %b want %h %b", op, bus.PCout, bus.taken, m_pc, m_taken); end
    end
  endtask

  task automatic test_call_ret();
    apply(1'b0, 1'b1, BR_BR, 1'b0, 1'b0, 32'h20);
    apply(1'b0, 1'b1, BR_CALL, 1'b0, 1'b0, 32'h100);
    n_cmp++; if (bus.PCout !== 32'h100 || bus.taken !== 1'b1 || bus.ras_empty !== 1'b0 || bus.ras_err !== 1'b0) begin n_bad++; $display("FAIL call: pc %h taken %b empty %b err %b want 100 1 0 0", bus.PCout, bus.taken, bus.ras_empty, bus.ras_err); end
    apply(1'b0, 1'b1, BR_RET, 1'b0, 1'b0, 32'h0);
    n_cmp++; if (bus.PCout !== 32'h24 || bus.taken !== 1'b1 || bus.ras_empty !== 1'b1 || bus.ras_err !== 1'b0) begin n_bad++; $display("FAIL ret: pc %h taken %b empty %b err %b want 24 1 1 0", bus.PCout, bus.taken, bus.ras_empty, bus.ras_err); end
  endtask

  task automatic test_ras_overflow();
    logic [31:0] exp_ret [4];
    exp_ret = '{32'h404, 32'h304, 32'h204, 32'h104};
    apply(1'b0, 1'b1, BR_BR, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      apply(1'b0, 1'b1, BR_CALL, 1'b0, 1'b0, 32'((i + 1) * 32'h100));
      n_cmp++; if (bus.ras_err !== (i == 4)) begin n_bad++; $display("FAIL call_err%0d: got %b want %b", i, bus.ras_err, (i == 4)); end
    end
    n_cmp++; if (bus.ras_full !== 1'b1) begin n_bad++; $display("FAIL ras_full: got %b want 1", bus.ras_full); end
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 1'b1, BR_RET, 1'b0, 1'b0, 32'h0);
      n_cmp++; if (bus.PCout !== exp_ret[i] || bus.taken !== 1'b1 || bus.ras_err !== 1'b0) begin n_bad++; $display("FAIL ret%0d: pc %h taken %b err %b want %h 1 0", i, bus.PCout, bus.taken, bus.ras_err, exp_ret[i]); end
    end
    apply(1'b0, 1'b1, BR_RET, 1'b0, 1'b0, 32'h0);
    n_cmp++; if (bus.PCout !== 32'h108 || bus.taken !== 1'b0 || bus.ras_err !== 1'b1) begin n_bad++; $display("FAIL ret_empty: pc %h taken %b err %b want 108 0 1", bus.PCout, bus.taken, bus.ras_err); end
    apply(1'b0, 1'b1, BR_NOP, 1'b0, 1'b0, 32'h0);
    n_cmp++; if (bus.ras_err !== 1'b0) begin n_bad++; $display("FAIL err_pulse: got %b want 0", bus.ras_err); end
  endtask

  task automatic test_stall();
    logic [31:0] held;
    held = m_pc;
    for (int i = 0; i < 2; i++) begin
      apply(1'b0, 1'b0, BR_BR, 1'b0, 1'b0, 32'h80);
      n_cmp++; if (bus.PCout !== held || bus.taken !== 1'b0) begin n_bad++; $display("FAIL stall%0d: pc %h taken %b want %h 0", i, bus.PCout, bus.taken, held); end
    end
    apply(1'b0, 1'b0, BR_CALL, 1'b0, 1'b0, 32'h80);
    n_cmp++; if (bus.ras_empty !== 1'b1 || bus.PCout !== held) begin n_bad++; $display("FAIL stall_call: empty %b pc %h want 1 %h", bus.ras_empty, bus.PCout, held); end
    apply(1'b1, 1'b0, BR_BR, 1'b0, 1'b0, 32'h80);
    n_cmp++; if (bus.PCout !== 32'h0) begin n_bad++; $display("FAIL stall_rst: got %h want 0", bus.PCout); end
  endtask

  task automatic test_wrap_and_count();
    logic [31:0] exp_cnt;
    apply(1'b0, 1'b1, BR_BR, 1'b0, 1'b0, 32'hFFFF_FFFC);
    apply(1'b0, 1'b1, BR_NOP, 1'b0, 1'b0, 32'h0);
    n_cmp++; if (bus.PCout !== 32'h0 || bus.taken !== 1'b0) begin n_bad++; $display("FAIL wrap: pc %h taken %b want 0 0", bus.PCout, bus.taken); end
    apply(1'b1, 1'b1, BR_NOP, 1'b0, 1'b0, 32'h0);
    apply(1'b0, 1'b1, BR_BR, 1'b0, 1'b0, 32'h40);
    apply(1'b0, 1'b1, BR_BZ, 1'b0, 1'b0, 32'h80);
    apply(1'b0, 1'b1, BR_BMI, 1'b0, 1'b1, 32'h80);
    apply(1'b0, 1'b0, BR_BR, 1'b0, 1'b0, 32'h90);
    apply(1'b0, 1'b1, BR_BNZ, 1'b0, 1'b0, 32'hC0);
`ifdef BRANCH_STATS_EN
    exp_cnt = 32'd3;
`else
    exp_cnt = 32'd0;
`endif
    n_cmp++; if (bus.taken_count !== exp_cnt) begin n_bad++; $display("FAIL taken_count: got %0d want %0d", bus.taken_count, exp_cnt); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      apply(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) != 0),
            br_op_t'($urandom), 1'($urandom), 1'($urandom),
            {$urandom_range(0, 1023), 2'b00});
      n_cmp++; if (bus.PCout !== m_pc) begin n_bad++; $display("FAIL rnd_pc%0d: got %h want %h", i, bus.PCout, m_pc); end
      n_cmp++; if (bus.taken !== m_taken || bus.ras_err !== m_err) begin n_bad++; $display("FAIL rnd_flags%0d: taken %b err %b want %b %b", i, bus.taken, bus.ras_err, m_taken, m_err); end
      n_cmp++; if (bus.ras_full !== (ras_m.size() == D) || bus.ras_empty !== (ras_m.size() == 0)) begin n_bad++; $display("FAIL rnd_ras%0d: full %b empty %b model size %0d", i, bus.ras_full, bus.ras_empty, ras_m.size()); end
      n_cmp++; if (bus.taken_count !== m_cnt) begin n_bad++; $display("FAIL rnd_count%0d: got %0d want %0d", i, bus.taken_count, m_cnt); end
    end
  endtask

  initial begin
    rst = 1'b0; bus.en = 1'b0; bus.BranchOp = BR_NOP;
    bus.zero = 1'b0; bus.neg = 1'b0; bus.target = 32'h0;
    m_pc = 32'h0; m_taken = 1'b0; m_err = 1'b0; m_cnt = 32'h0;
    test_reset();
    test_conditional();
    test_call_ret();
    test_ras_overflow();
    test_stall();
    test_wrap_and_count();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
